// File: rtl/mac_ingress_arb.sv
// Round-robin N-port ingress arbiter: splits each granted RX frame into a header word and body bytes, drops runts.
// Latency: grant to first rden 1 cycle, 1 byte per 2 clk; the header is written after the last body byte.
// Backpressure: no grant while h_fifo_full/b_fifo_afull; body reads stall on b_fifo_afull; header write waits on h_fifo_full.
module mac_ingress_arb #(
    parameter int NUM_PORTS     = 4,
    parameter int PORT_IDX_W    = 2,
    parameter int HEADER_DWIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*NUM_PORTS-1:0]   i_fifo_dout,
    input  logic [NUM_PORTS-1:0]     i_fifo_del,
    input  logic [NUM_PORTS-1:0]     i_fifo_empty,
    output logic [NUM_PORTS-1:0]     i_fifo_rden,
    input  logic [NUM_PORTS-1:0]     port_enable,
    output logic [HEADER_DWIDTH-1:0] h_fifo_din,
    output logic                     h_fifo_wren,
    input  logic                     h_fifo_full,
    output logic [7:0]               b_fifo_din,
    output logic                     b_fifo_wren,
    output logic                     b_fifo_del,
    input  logic                     b_fifo_afull,
    output logic                     drop_pulse,
    output logic [PORT_IDX_W-1:0]    drop_port
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_BODY   = 3'd2,
        S_WR_HDR = 3'd3,
        S_DROP   = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [PORT_IDX_W-1:0]   grant;
    logic [PORT_IDX_W-1:0]   last_grant;
    logic [PORT_IDX_W-1:0]   rr_idx;
    logic                    rr_found;
    logic [NUM_PORTS-1:0]    req;
    int                      j;
    logic                    rd_pend;    // a read was issued last cycle, its byte is on dout now
    logic                    rd_ok;
    logic                    last_pend;  // del byte captured and held, still to be written
    logic [3:0]              byte_idx;   // index of next byte while in HDR (0..14)
    logic [111:0]            hdr_sh;     // DA, SA, EtherType shifted in MSB first
    logic [7:0]              hold;       // body byte kept in hand until the next capture
    logic [10:0]             body_cnt;
    logic [7:0]              cap_dat;
    logic                    cap_del;
    logic                    gnt_empty;
    logic [127:0]            hdr_word;

    assign hdr_word = {hdr_sh, body_cnt, 5'(grant)};

    // Round-robin search over enabled, non-empty ports starting after last_grant.
    always_comb begin
        req      = port_enable & ~i_fifo_empty;
        rr_found = 1'b0;
        rr_idx   = last_grant;
        j        = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            j = (int'(last_grant) + i) % NUM_PORTS;
            if (!rr_found && req[j]) begin
                rr_found = 1'b1;
                rr_idx   = PORT_IDX_W'(j);
            end
        end
    end

    // Select the granted port's data, del and empty flags.
    always_comb begin
        cap_dat   = '0;
        cap_del   = 1'b0;
        gnt_empty = 1'b1;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant == PORT_IDX_W'(k)) begin
                cap_dat   = i_fifo_dout[8*k +: 8];
                cap_del   = i_fifo_del[k];
                gnt_empty = i_fifo_empty[k];
            end
        end
    end

    // Read enable: every other cycle at most, never on empty, never past del, stalled by body almost-full.
    always_comb begin
        rd_ok       = 1'b0;
        i_fifo_rden = '0;
        if (!rd_pend && !gnt_empty) begin
            if (state == S_HDR) begin
                rd_ok = 1'b1;
            end else if (state == S_BODY && !b_fifo_afull && !last_pend) begin
                rd_ok = 1'b1;
            end
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            i_fifo_rden[k] = rd_ok && (grant == PORT_IDX_W'(k));
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a del anywhere in bytes 0..14 makes the frame a runt.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (rr_found && !h_fifo_full && !b_fifo_afull) begin
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (rd_pend) begin
                    if (cap_del) begin
                        state_nxt = S_DROP;
                    end else if (byte_idx == 4'd14) begin
                        state_nxt = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (last_pend) begin
                    state_nxt = S_WR_HDR;
                end
            end
            S_WR_HDR: begin
                if (!h_fifo_full) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DROP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: grant bookkeeping, header capture, body write pipeline, header and drop reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= '0;
            last_grant  <= PORT_IDX_W'(NUM_PORTS - 1);
            rd_pend     <= 1'b0;
            last_pend   <= 1'b0;
            byte_idx    <= '0;
            hdr_sh      <= '0;
            hold        <= '0;
            body_cnt    <= '0;
            h_fifo_din  <= '0;
            h_fifo_wren <= 1'b0;
            b_fifo_din  <= '0;
            b_fifo_wren <= 1'b0;
            b_fifo_del  <= 1'b0;
            drop_pulse  <= 1'b0;
            drop_port   <= '0;
        end else begin
            rd_pend     <= rd_ok;
            h_fifo_wren <= 1'b0;
            b_fifo_wren <= 1'b0;
            b_fifo_del  <= 1'b0;
            drop_pulse  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_HDR) begin
                        grant      <= rr_idx;
                        last_grant <= rr_idx;
                        byte_idx   <= '0;
                        body_cnt   <= '0;
                        last_pend  <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (rd_pend) begin
                        if (cap_del) begin
                            drop_pulse <= 1'b1;
                            drop_port  <= grant;
                        end else begin
                            if (byte_idx == 4'd14) begin
                                hold <= cap_dat;
                            end else begin
                                hdr_sh <= {hdr_sh[103:0], cap_dat};
                            end
                            byte_idx <= byte_idx + 4'd1;
                        end
                    end
                end
                S_BODY: begin
                    // Body bytes trail the capture by one byte so the last write can carry del.
                    if (last_pend) begin
                        b_fifo_wren <= 1'b1;
                        b_fifo_din  <= hold;
                        b_fifo_del  <= 1'b1;
                        body_cnt    <= (body_cnt == 11'h7FF) ? body_cnt : body_cnt + 11'd1;
                    end else if (rd_pend) begin
                        b_fifo_wren <= 1'b1;
                        b_fifo_din  <= hold;
                        hold        <= cap_dat;
                        body_cnt    <= (body_cnt == 11'h7FF) ? body_cnt : body_cnt + 11'd1;
                        if (cap_del) begin
                            last_pend <= 1'b1;
                        end
                    end
                end
                S_WR_HDR: begin
                    if (!h_fifo_full) begin
                        h_fifo_wren <= 1'b1;
                        h_fifo_din  <= HEADER_DWIDTH'(hdr_word);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_ingress_arb.sv
// Scoreboard bench for mac_ingress_arb: RX FIFO models feed frames, expected writes are queued at stimulus time.
// A negedge monitor pops and compares body bytes, headers and drops, and checks the read protocol.
// Covers contention, single frame, runts, backpressure, enable mask and reset.
module tb_mac_ingress_arb;

    localparam int NP = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [8*NP-1:0] i_fifo_dout;
    logic [NP-1:0]   i_fifo_del;
    logic [NP-1:0]   i_fifo_empty;
    logic [NP-1:0]   i_fifo_rden;
    logic [NP-1:0]   port_enable;
    logic [127:0]    h_fifo_din;
    logic            h_fifo_wren;
    logic            h_fifo_full;
    logic [7:0]      b_fifo_din;
    logic            b_fifo_wren;
    logic            b_fifo_del;
    logic            b_fifo_afull;
    logic            drop_pulse;
    logic [1:0]      drop_port;

    int n_chk  = 0;
    int n_fail = 0;
    int n_body = 0;
    int n_hdr  = 0;
    bit ignore = 1'b0;

    logic [8:0]   rxq [NP][$];
    logic [8:0]   rx_e;
    logic [8:0]   exp_body [$];
    logic [127:0] exp_hdr [$];
    logic [1:0]   exp_drop [$];
    logic [NP-1:0] prev_rden = '0;

    always #5 clk = ~clk;

    mac_ingress_arb #(.NUM_PORTS(NP), .PORT_IDX_W(2), .HEADER_DWIDTH(128)) dut (
        .clk(clk), .rst(rst),
        .i_fifo_dout(i_fifo_dout), .i_fifo_del(i_fifo_del), .i_fifo_empty(i_fifo_empty),
        .i_fifo_rden(i_fifo_rden), .port_enable(port_enable),
        .h_fifo_din(h_fifo_din), .h_fifo_wren(h_fifo_wren), .h_fifo_full(h_fifo_full),
        .b_fifo_din(b_fifo_din), .b_fifo_wren(b_fifo_wren), .b_fifo_del(b_fifo_del),
        .b_fifo_afull(b_fifo_afull), .drop_pulse(drop_pulse), .drop_port(drop_port)
    );

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // RX FIFO models with one-cycle read latency; cleared by the shared reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NP; k++) rxq[k].delete();
            i_fifo_empty <= '1;
            i_fifo_dout  <= '0;
            i_fifo_del   <= '0;
        end else begin
            for (int k = 0; k < NP; k++) begin
                if (i_fifo_rden[k] && rxq[k].size() > 0) begin
                    rx_e = rxq[k].pop_front();
                    i_fifo_dout[8*k +: 8] <= rx_e[7:0];
                    i_fifo_del[k]         <= rx_e[8];
                end
                i_fifo_empty[k] <= (rxq[k].size() == 0);
            end
        end
    end

    // Monitor: read protocol checks and scoreboard comparisons of every DUT write.
    always @(negedge clk) begin
        if (!rst) begin
            if (|i_fifo_rden) begin
                check("rden_onehot", 128'($countones(i_fifo_rden)), 128'd1);
                check("rden_back_to_back", 128'(i_fifo_rden & prev_rden), 128'd0);
                check("rden_when_empty", 128'(i_fifo_rden & i_fifo_empty), 128'd0);
                if (b_fifo_afull) check("rden_under_afull", 128'(i_fifo_rden), 128'd0);
            end
            if (b_fifo_wren) begin
                n_body++;
                if (!ignore) begin
                    if (exp_body.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL body_unexpected: got %h, expected no write", {b_fifo_del, b_fifo_din});
                    end else begin
                        check("body_byte", 128'({b_fifo_del, b_fifo_din}), 128'(exp_body.pop_front()));
                    end
                end
            end
            if (h_fifo_wren) begin
                n_hdr++;
                if (!ignore) begin
                    if (exp_hdr.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL hdr_unexpected: got %h, expected no write", h_fifo_din);
                    end else begin
                        check("header", h_fifo_din, exp_hdr.pop_front());
                    end
                end
            end
            if (drop_pulse && !ignore) begin
                if (exp_drop.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL drop_unexpected: got port %0d, expected no drop", drop_port);
                end else begin
                    check("drop_port", 128'(drop_port), 128'(exp_drop.pop_front()));
                end
            end
        end
        prev_rden = i_fifo_rden;
    end

    function automatic logic [111:0] hdr_of(int p, int seed);
        return {48'(seed * 3 + p + 1), 48'hA0A1A2A3A4A5 ^ 48'(seed), 16'h0800 + 16'(p)};
    endfunction

    task automatic load_frame(int p, int len, logic [111:0] hdr, int seed);
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = (i < 14) ? hdr[111 - 8*i -: 8] : 8'(i + seed);
            rxq[p].push_back({(i == len - 1), b});
        end
    endtask

    task automatic expect_frame(int len, logic [127:0] hw, int seed);
        for (int i = 14; i < len; i++) exp_body.push_back({(i == len - 1), 8'(i + seed)});
        exp_hdr.push_back(hw);
    endtask

    task automatic send(int p, int len, int seed);
        load_frame(p, len, hdr_of(p, seed), seed);
        expect_frame(len, {hdr_of(p, seed), 11'(len - 14), 5'(p)}, seed);
    endtask

    task automatic wait_drain(string name);
        int c = 0;
        while ((exp_body.size() + exp_hdr.size() + exp_drop.size()) != 0 && c < 3000) begin
            @(negedge clk); c++;
        end
        check(name, 128'(exp_body.size() + exp_hdr.size() + exp_drop.size()), 128'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_body(string name, int target);
        int c = 0;
        while (n_body < target && c < 2000) begin
            @(negedge clk); c++;
        end
        check(name, 128'(n_body >= target), 128'd1);
    endtask

    task automatic check_outputs_zero(string tag);
        check({tag, "_rden"}, 128'(i_fifo_rden), 128'd0);
        check({tag, "_b_wren"}, 128'(b_fifo_wren), 128'd0);
        check({tag, "_b_din"}, 128'({b_fifo_del, b_fifo_din}), 128'd0);
        check({tag, "_h_wren"}, 128'(h_fifo_wren), 128'd0);
        check({tag, "_h_din"}, h_fifo_din, 128'd0);
        check({tag, "_drop"}, 128'({drop_pulse, drop_port}), 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, h0;
        rst = 1'b1; port_enable = 4'b1111; h_fifo_full = 1'b0; b_fifo_afull = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Contention from reset: port 0 favoured, then strict rotation.
        send(0, 20, 0); send(1, 20, 16); send(2, 20, 32); send(3, 20, 48); send(0, 20, 100);
        wait_drain("contention_drain");

        // Single 64-byte frame on port 0: 50 body bytes, header count 50, port 0.
        b0 = n_body;
        load_frame(0, 64, 112'h0102030405060A0B0C0D0E0F0800, 0);
        expect_frame(64, 128'h0102030405060A0B0C0D0E0F08000640, 0);
        wait_drain("single_drain");
        check("single_body_count", 128'(n_body - b0), 128'd50);

        // Runts on port 2: 10 and 15 bytes, each dropped with nothing written.
        b0 = n_body; h0 = n_hdr;
        load_frame(2, 10, hdr_of(2, 7), 7); exp_drop.push_back(2'd2);
        wait_drain("runt10_drain");
        load_frame(2, 15, hdr_of(2, 9), 9); exp_drop.push_back(2'd2);
        wait_drain("runt15_drain");
        check("runt_no_body", 128'(n_body - b0), 128'd0);
        check("runt_no_hdr", 128'(n_hdr - h0), 128'd0);
        check("runt_consumed", 128'(rxq[2].size()), 128'd0);
        check("drop_port_held", 128'(drop_port), 128'd2);

        // Backpressure: body almost-full for 20 cycles, then header FIFO full across WR_HDR.
        b0 = n_body;
        send(1, 64, 3);
        wait_body("bp_start", b0 + 10);
        b_fifo_afull = 1'b1;
        repeat (20) @(negedge clk);
        b_fifo_afull = 1'b0;
        wait_body("bp_resume", b0 + 40);
        h_fifo_full = 1'b1;
        wait_body("bp_last_byte", b0 + 50);
        h0 = n_hdr;
        repeat (5) @(negedge clk);
        check("hdr_held_while_full", 128'(n_hdr - h0), 128'd0);
        h_fifo_full = 1'b0;
        wait_drain("bp_drain");

        // Enable mask 1010: only ports 3 then 1 served; ports 0 and 2 left waiting.
        port_enable = 4'b1010;
        send(3, 20, 60); send(1, 20, 70);
        load_frame(0, 20, hdr_of(0, 80), 80);
        load_frame(2, 20, hdr_of(2, 90), 90);
        wait_drain("mask_drain");
        check("mask_port0_waiting", 128'(rxq[0].size()), 128'd20);
        check("mask_port2_waiting", 128'(rxq[2].size()), 128'd20);

        // Disabling port 1 mid-frame does not abort it.
        b0 = n_body;
        send(1, 64, 5);
        wait_body("mask_mid_start", b0 + 5);
        port_enable = 4'b1000;
        wait_drain("mask_mid_drain");

        // Re-enable all: rotation from port 1 serves 2 then 0.
        expect_frame(20, {hdr_of(2, 90), 11'd6, 5'd2}, 90);
        expect_frame(20, {hdr_of(0, 80), 11'd6, 5'd0}, 80);
        port_enable = 4'b1111;
        wait_drain("mask_rest_drain");

        // Reset mid-body: outputs clear, rotation restarts so port 1 beats port 3.
        ignore = 1'b1;
        b0 = n_body;
        load_frame(2, 64, hdr_of(2, 1), 1);
        wait_body("rst_mid_start", b0 + 5);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("midreset");
        rst = 1'b0;
        ignore = 1'b0;
        @(negedge clk);
        send(1, 20, 40); send(3, 20, 44);
        wait_drain("post_reset_drain");
        check("all_rx_empty", 128'(rxq[0].size() + rxq[1].size() + rxq[2].size() + rxq[3].size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
